fetch_unit: RTL

- Front-end fetch stage sitting directly upstream of the icache.
- Holds the PC and issues word-granularity read requests on the icache core interface (REN/addr/halt, hit/load).
- Buffers returned instructions with their PCs in a small in-order instruction queue (IQ) consumed by decode.
- Handles redirects (branch/jump resolution) and program halt.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage feeding decode from the icache.
//   Holds the PC, issues blocking word reads to the icache (REN/addr/halt,
//   hit/load), and buffers {pc, instr} pairs in an in-order instruction
//   queue (IQ) popped by decode. Handles redirects and a permanent halt.
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   icache_REN       read request (asserted until hit)
//   icache_addr      current PC
//   icache_halt      registered halt indication to the icache
//   icache_hit       icache returned icache_load for icache_addr this cycle
//   icache_load      instruction word
//   iq_valid         IQ head valid
//   iq_instr, iq_pc  IQ head instruction and its PC
//   iq_ready         decode consumes head
//   redirect_valid   flush IQ and restart fetch at redirect_pc
//   redirect_pc      new fetch PC (low two bits dropped)
//   halt             stop fetching until reset
//   halted           unit is in the HALT state
module fetch_unit #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        icache_REN,
  output logic [31:0] icache_addr,
  output logic        icache_halt,
  input  logic        icache_hit,
  input  logic [31:0] icache_load,
  output logic        iq_valid,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  input  logic        iq_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  localparam int unsigned PW = $clog2(IQ_DEPTH);
  localparam int unsigned CW = $clog2(IQ_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  typedef enum logic {
    FETCH,
    HALT
  } state_t;

  state_t state, state_next;

  logic [31:0]   pc;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   iq_instr_mem [IQ_DEPTH];
  logic [31:0]   iq_pc_mem    [IQ_DEPTH];

  logic fetching;
  logic push, pop, flush;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state logic: HALT is only left through reset
  always_comb begin
    state_next = state;
    if (state == FETCH && halt) state_next = HALT;
  end

  // Outputs and per-cycle control
  always_comb begin
    fetching    = (state == FETCH);
    halted      = (state == HALT);
    icache_halt = halted;
    // Full check uses the registered count: a same-cycle pop frees nothing.
    icache_REN  = fetching & (count < DEPTH_C) & ~redirect_valid & ~halt & ~RST;
    icache_addr = pc;
    iq_valid    = fetching & (count != '0);
    iq_instr    = iq_instr_mem[head];
    iq_pc       = iq_pc_mem[head];
    flush       = fetching & (halt | redirect_valid);
    // REN already excludes halt/redirect, so a push never races a flush.
    push        = icache_REN & icache_hit;
    pop         = iq_valid & iq_ready & ~flush;
  end

  // IQ storage: no reset needed, validity is tracked by count
  always_ff @(posedge CLK) begin
    if (push) begin
      iq_instr_mem[tail] <= icache_load;
      iq_pc_mem[tail]    <= pc;
    end
  end

  // PC and queue pointers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // halt outranks redirect: the PC is only reloaded on a pure redirect
      if (!halt) pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (fetching) begin
      if (push) begin
        tail <= tail + PW'(1);
        pc   <= pc + 32'd4;
      end
      if (pop) head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule
